bus_arbiter2: RTL and testbench

- Two-master, one-slave arbiter between the bus masters (CPU, plus a second master such as a DMA/copy engine) and the MemoryUnit bus.
- Latches each master's single-cycle start request and grants masters round-robin.
- Issues one transaction at a time to the MemoryUnit and returns read data/done to the granted master.
- The MemoryUnit sees one master with the unchanged start/done protocol.

---
 rtl/bus_arbiter2.sv | 226 ++++++++++++++++++++++
 tb/tb_bus_arbiter2.sv | 478 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter2.sv
// bus_arbiter2
//   Two-master, one-slave arbiter in front of the MemoryUnit bus. Each master
//   issues a single-cycle start pulse. The pulse is latched into a per-master
//   request slot. Pending requests are granted round-robin and forwarded one
//   at a time to the MemoryUnit, which sees an ordinary single master using
//   the usual start/done handshake. Read data and the done pulse are returned
//   only to the master that owns the transaction.
//
// Ports
//   clk, nreset              system clock, asynchronous active-low reset
//   m0_addr/data/we/start    master 0 (CPU) request inputs
//   m0_q, m0_done            master 0 read data and completion pulse
//   m1_*                     same set for master 1 (DMA / copy engine)
//   bus_addr/data/we/start   request towards the MemoryUnit (registered)
//   bus_q, bus_done          response from the MemoryUnit
//   timeout_err              sticky flag, set when a transaction times out
//
// Optional feature
//   BUS_ARB_TIMEOUT_EN: when defined, a transaction left in WAIT for
//   TIMEOUT_CYCLES cycles is completed with all-ones read data, and
//   timeout_err is set. When undefined, WAIT has no time limit and
//   timeout_err is tied low.

module bus_arbiter2 #(
  parameter int ADDR_W         = 27,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_data,
  input  logic              m0_we,
  input  logic              m0_start,
  output logic [DATA_W-1:0] m0_q,
  output logic              m0_done,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_data,
  input  logic              m1_we,
  input  logic              m1_start,
  output logic [DATA_W-1:0] m1_q,
  output logic              m1_done,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_data,
  output logic              bus_we,
  output logic              bus_start,
  input  logic [DATA_W-1:0] bus_q,
  input  logic              bus_done,
  output logic              timeout_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t            state, state_d;
  logic              pend0, pend1;
  logic [ADDR_W-1:0] req0_addr, req1_addr;
  logic [DATA_W-1:0] req0_data, req1_data;
  logic              req0_we, req1_we;
  logic              grant, grant_d;
  logic              last_grant, last_grant_d;
  logic [ADDR_W-1:0] bus_addr_d;
  logic [DATA_W-1:0] bus_data_d;
  logic              bus_we_d;
  logic              bus_start_d;
  logic [DATA_W-1:0] m0_q_d, m1_q_d;
  logic              m0_done_d, m1_done_d;
  logic              complete;
  logic              timeout_hit;
  logic [DATA_W-1:0] resp_data;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("bus_arbiter2: TIMEOUT_CYCLES must be at least 1");
  end

  // Request slots. Each slot holds one request. A start pulse that arrives
  // while the slot is already full is a protocol violation and is dropped.
  // A slot is freed on the edge where its transaction completes.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      pend0     <= 1'b0;
      pend1     <= 1'b0;
      req0_addr <= '0;
      req0_data <= '0;
      req0_we   <= 1'b0;
      req1_addr <= '0;
      req1_data <= '0;
      req1_we   <= 1'b0;
    end else begin
      if (m0_start && !pend0) begin
        pend0     <= 1'b1;
        req0_addr <= m0_addr;
        req0_data <= m0_data;
        req0_we   <= m0_we;
      end else if (complete && !grant) begin
        pend0 <= 1'b0;
      end
      if (m1_start && !pend1) begin
        pend1     <= 1'b1;
        req1_addr <= m1_addr;
        req1_data <= m1_data;
        req1_we   <= m1_we;
      end else if (complete && grant) begin
        pend1 <= 1'b0;
      end
    end
  end

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             timeout_flag;

  // The counter stays at zero outside WAIT, so it always starts from zero
  // when WAIT is entered. The timeout fires on the last permitted WAIT cycle.
  // This makes the forced completion appear TIMEOUT_CYCLES cycles after WAIT
  // was entered.
  assign timeout_hit = (state == WAIT) && !bus_done &&
                       (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign timeout_err = timeout_flag;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wait_cnt     <= '0;
      timeout_flag <= 1'b0;
    end else begin
      if (state != WAIT) begin
        wait_cnt <= '0;
      end else if (!bus_done) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end
      if (timeout_hit) begin
        timeout_flag <= 1'b1;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // A timed-out transaction returns all-ones in place of MemoryUnit data.
  assign resp_data = bus_done ? bus_q : '1;

  // Next-state and next-output logic. Every output is registered, so this
  // block computes the values for the following cycle. The bus request
  // fields change only at grant time, so they stay stable through ISSUE and
  // WAIT. A bus_done seen outside WAIT is ignored.
  always_comb begin
    state_d      = state;
    grant_d      = grant;
    last_grant_d = last_grant;
    bus_addr_d   = bus_addr;
    bus_data_d   = bus_data;
    bus_we_d     = bus_we;
    bus_start_d  = 1'b0;
    m0_q_d       = m0_q;
    m1_q_d       = m1_q;
    m0_done_d    = 1'b0;
    m1_done_d    = 1'b0;
    complete     = 1'b0;
    case (state)
      IDLE: begin
        if (pend0 || pend1) begin
          // On a tie, the master that was not served last wins. Otherwise
          // the only pending master is granted.
          grant_d     = (pend0 && pend1) ? ~last_grant : ~pend0;
          bus_addr_d  = grant_d ? req1_addr : req0_addr;
          bus_data_d  = grant_d ? req1_data : req0_data;
          bus_we_d    = grant_d ? req1_we   : req0_we;
          bus_start_d = 1'b1;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (bus_done || timeout_hit) begin
          complete     = 1'b1;
          last_grant_d = grant;
          state_d      = IDLE;
          if (grant) begin
            m1_q_d    = resp_data;
            m1_done_d = 1'b1;
          end else begin
            m0_q_d    = resp_data;
            m0_done_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers. After reset, last_grant is 1, so master 0
  // wins the first tie.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      bus_addr   <= '0;
      bus_data   <= '0;
      bus_we     <= 1'b0;
      bus_start  <= 1'b0;
      m0_q       <= '0;
      m1_q       <= '0;
      m0_done    <= 1'b0;
      m1_done    <= 1'b0;
    end else begin
      state      <= state_d;
      grant      <= grant_d;
      last_grant <= last_grant_d;
      bus_addr   <= bus_addr_d;
      bus_data   <= bus_data_d;
      bus_we     <= bus_we_d;
      bus_start  <= bus_start_d;
      m0_q       <= m0_q_d;
      m1_q       <= m1_q_d;
      m0_done    <= m0_done_d;
      m1_done    <= m1_done_d;
    end
  end

endmodule

// File: tb/tb_bus_arbiter2.sv
// tb_bus_arbiter2
//   Testbench for bus_arbiter2. It plays both masters and the MemoryUnit.
//   A vector table covers simultaneous requests from reset. Hand-written
//   sequences cover a single read, fairness, duplicate starts, reset during
//   WAIT and, in the timeout build, the WAIT timeout. A randomized run is
//   compared against a timestamp-based reference model.

module tb_bus_arbiter2;

  localparam int ADDR_W = 27;
  localparam int DATA_W = 32;
`ifdef BUS_ARB_TIMEOUT_EN
  localparam int TB_TIMEOUT = 16;
`else
  localparam int TB_TIMEOUT = 1024;
`endif

  logic              clk = 1'b0;
  logic              nreset = 1'b0;
  logic [ADDR_W-1:0] m0_addr = '0, m1_addr = '0;
  logic [DATA_W-1:0] m0_data = '0, m1_data = '0;
  logic              m0_we = 1'b0, m1_we = 1'b0;
  logic              m0_start = 1'b0, m1_start = 1'b0;
  logic [DATA_W-1:0] m0_q, m1_q;
  logic              m0_done, m1_done;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_data;
  logic              bus_we, bus_start;
  logic [DATA_W-1:0] bus_q = '0;
  logic              bus_done = 1'b0;
  logic              timeout_err;

  typedef struct packed {
    logic              m0_start;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_data;
    logic              m0_we;
    logic              m1_start;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_data;
    logic              m1_we;
    logic              bus_done;
    logic [DATA_W-1:0] bus_q;
  } stim_t;

  typedef struct packed {
    stim_t             in;
    logic              exp_start;
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] exp_data;
    logic              exp_we;
    logic              exp_d0;
    logic              exp_d1;
    logic [DATA_W-1:0] exp_q0;
    logic [DATA_W-1:0] exp_q1;
  } vec_t;

  int assert_count = 0;
  int fail_count   = 0;

  always #5 clk = ~clk;

  bus_arbiter2 #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .TIMEOUT_CYCLES(TB_TIMEOUT)
  ) dut (
    .clk(clk),
    .nreset(nreset),
    .m0_addr(m0_addr),
    .m0_data(m0_data),
    .m0_we(m0_we),
    .m0_start(m0_start),
    .m0_q(m0_q),
    .m0_done(m0_done),
    .m1_addr(m1_addr),
    .m1_data(m1_data),
    .m1_we(m1_we),
    .m1_start(m1_start),
    .m1_q(m1_q),
    .m1_done(m1_done),
    .bus_addr(bus_addr),
    .bus_data(bus_data),
    .bus_we(bus_we),
    .bus_start(bus_start),
    .bus_q(bus_q),
    .bus_done(bus_done),
    .timeout_err(timeout_err)
  );

  // Drives one cycle's inputs, without waiting for a clock edge.
  task automatic drive(input stim_t s);
    m0_start = s.m0_start;
    m0_addr  = s.m0_addr;
    m0_data  = s.m0_data;
    m0_we    = s.m0_we;
    m1_start = s.m1_start;
    m1_addr  = s.m1_addr;
    m1_data  = s.m1_data;
    m1_we    = s.m1_we;
    bus_done = s.bus_done;
    bus_q    = s.bus_q;
  endtask

  // Starts a new cycle just after the rising edge and applies its inputs.
  task automatic applyStimulus(input stim_t s);
    @(posedge clk);
    #1;
    drive(s);
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic check_all_zero(input string tag);
    checkOutput({tag, " bus_start"}, bus_start, 0);
    checkOutput({tag, " bus_addr"}, bus_addr, 0);
    checkOutput({tag, " bus_data"}, bus_data, 0);
    checkOutput({tag, " bus_we"}, bus_we, 0);
    checkOutput({tag, " m0_q"}, m0_q, 0);
    checkOutput({tag, " m1_q"}, m1_q, 0);
    checkOutput({tag, " m0_done"}, m0_done, 0);
    checkOutput({tag, " m1_done"}, m1_done, 0);
    checkOutput({tag, " timeout_err"}, timeout_err, 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    nreset = 1'b0;
    drive('0);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1;
    nreset = 1'b1;
  endtask

  // Simultaneous write from m0 and read from m1, starting from reset.
  task automatic run_table();
    vec_t vecs[10];
    for (int i = 0; i < 10; i++) vecs[i] = '0;
    vecs[0].in.m0_start = 1'b1;
    vecs[0].in.m0_addr  = 27'h10;
    vecs[0].in.m0_data  = 32'h11;
    vecs[0].in.m0_we    = 1'b1;
    vecs[0].in.m1_start = 1'b1;
    vecs[0].in.m1_addr  = 27'h20;
    vecs[0].in.m1_data  = 32'h99;
    vecs[3].in.bus_done = 1'b1;
    vecs[3].in.bus_q    = 32'hAAAA0001;
    vecs[7].in.bus_done = 1'b1;
    vecs[7].in.bus_q    = 32'h55550002;
    vecs[2].exp_start = 1'b1;
    vecs[5].exp_start = 1'b1;
    for (int i = 2; i <= 4; i++) begin
      vecs[i].exp_addr = 27'h10;
      vecs[i].exp_data = 32'h11;
      vecs[i].exp_we   = 1'b1;
    end
    for (int i = 5; i <= 9; i++) begin
      vecs[i].exp_addr = 27'h20;
      vecs[i].exp_data = 32'h99;
    end
    vecs[4].exp_d0 = 1'b1;
    vecs[8].exp_d1 = 1'b1;
    for (int i = 4; i <= 9; i++) vecs[i].exp_q0 = 32'hAAAA0001;
    for (int i = 8; i <= 9; i++) vecs[i].exp_q1 = 32'h55550002;

    do_reset();
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].in);
      @(negedge clk);
      checkOutput($sformatf("tbl%0d bus_start", i), bus_start, vecs[i].exp_start);
      checkOutput($sformatf("tbl%0d bus_addr", i), bus_addr, vecs[i].exp_addr);
      checkOutput($sformatf("tbl%0d bus_data", i), bus_data, vecs[i].exp_data);
      checkOutput($sformatf("tbl%0d bus_we", i), bus_we, vecs[i].exp_we);
      checkOutput($sformatf("tbl%0d m0_done", i), m0_done, vecs[i].exp_d0);
      checkOutput($sformatf("tbl%0d m1_done", i), m1_done, vecs[i].exp_d1);
      checkOutput($sformatf("tbl%0d m0_q", i), m0_q, vecs[i].exp_q0);
      checkOutput($sformatf("tbl%0d m1_q", i), m1_q, vecs[i].exp_q1);
    end
  endtask

  task automatic run_single_read();
    stim_t s;
    do_reset();
    for (int c = 0; c <= 8; c++) begin
      s = '0;
      if (c == 0) begin
        s.m0_start = 1'b1;
        s.m0_addr  = 27'h0000100;
      end
      if (c == 5) begin
        s.bus_done = 1'b1;
        s.bus_q    = 32'hDEADBEEF;
      end
      applyStimulus(s);
      @(negedge clk);
      checkOutput($sformatf("single bus_start c%0d", c), bus_start, (c == 2));
      checkOutput($sformatf("single m0_done c%0d", c), m0_done, (c == 6));
      checkOutput($sformatf("single m1_done c%0d", c), m1_done, 0);
      if (c == 2) begin
        checkOutput("single bus_addr", bus_addr, 27'h0000100);
        checkOutput("single bus_we", bus_we, 0);
      end
      if (c >= 6) checkOutput($sformatf("single m0_q c%0d", c), m0_q, 32'hDEADBEEF);
    end
  endtask

  // Both masters request again as soon as they see their own done.
  task automatic run_fairness();
    stim_t s;
    int    grants = 0;
    int    mem_due = -1;
    bit    again0 = 1'b1, again1 = 1'b1;
    int    order[6];
    do_reset();
    for (int c = 0; c < 200 && grants < 6; c++) begin
      s = '0;
      if (again0) begin
        s.m0_start = 1'b1;
        s.m0_addr  = 27'h0AA;
      end
      if (again1) begin
        s.m1_start = 1'b1;
        s.m1_addr  = 27'h0BB;
      end
      if (c == mem_due) begin
        s.bus_done = 1'b1;
        s.bus_q    = DATA_W'(c);
      end
      again0 = 1'b0;
      again1 = 1'b0;
      applyStimulus(s);
      @(negedge clk);
      if (bus_start) begin
        order[grants] = (bus_addr == 27'h0BB) ? 1 : 0;
        grants++;
        mem_due = c + 2;
      end
      if (m0_done) again0 = 1'b1;
      if (m1_done) again1 = 1'b1;
    end
    checkOutput("fair grant count", grants, 6);
    for (int i = 0; i < grants; i++)
      checkOutput($sformatf("fair order %0d", i), order[i], i % 2);
  endtask

  task automatic run_duplicate();
    stim_t s;
    int    starts = 0, d0 = 0, d1 = 0, mem_due = -1;
    logic [ADDR_W-1:0] first_addr = '0;
    do_reset();
    for (int c = 0; c < 20; c++) begin
      s = '0;
      if (c <= 2) begin
        s.m1_start = 1'b1;
        s.m1_addr  = (c == 0) ? 27'h123 : 27'h456;
      end
      if (c == mem_due) begin
        s.bus_done = 1'b1;
        s.bus_q    = 32'hCAFE0000;
      end
      applyStimulus(s);
      @(negedge clk);
      if (bus_start) begin
        if (starts == 0) first_addr = bus_addr;
        starts++;
        mem_due = c + 2;
      end
      if (m0_done) d0++;
      if (m1_done) d1++;
    end
    checkOutput("dup bus_start count", starts, 1);
    checkOutput("dup first addr", first_addr, 27'h123);
    checkOutput("dup m1_done count", d1, 1);
    checkOutput("dup m0_done count", d0, 0);
  endtask

  task automatic run_reset_midwait();
    stim_t s;
    do_reset();
    for (int c = 0; c <= 3; c++) begin
      s = '0;
      if (c == 0) begin
        s.m0_start = 1'b1;
        s.m0_addr  = 27'h55;
        s.m0_data  = 32'h77;
        s.m0_we    = 1'b1;
      end
      applyStimulus(s);
      @(negedge clk);
    end
    checkOutput("midwait bus_start", bus_start, 0);
    checkOutput("midwait bus_addr", bus_addr, 27'h55);
    #2;
    nreset = 1'b0;
    #1;
    check_all_zero("midwait async");
    @(posedge clk);
    #1;
    nreset = 1'b1;
    for (int c = 0; c < 6; c++) begin
      s = '0;
      if (c == 0) begin
        s.bus_done = 1'b1;
        s.bus_q    = 32'h1234;
      end
      applyStimulus(s);
      @(negedge clk);
      checkOutput($sformatf("midwait quiet m0_done c%0d", c), m0_done, 0);
      checkOutput($sformatf("midwait quiet m1_done c%0d", c), m1_done, 0);
      checkOutput($sformatf("midwait quiet bus_start c%0d", c), bus_start, 0);
      checkOutput($sformatf("midwait quiet m0_q c%0d", c), m0_q, 0);
    end
    for (int c = 0; c <= 3; c++) begin
      s = '0;
      if (c == 0) begin
        s.m0_start = 1'b1;
        s.m0_addr  = 27'h66;
      end
      applyStimulus(s);
      @(negedge clk);
      checkOutput($sformatf("midwait reissue bus_start c%0d", c), bus_start, (c == 2));
      if (c == 2) checkOutput("midwait reissue bus_addr", bus_addr, 27'h66);
    end
  endtask

`ifdef BUS_ARB_TIMEOUT_EN
  task automatic run_timeout();
    stim_t s;
    do_reset();
    for (int c = 0; c <= 24; c++) begin
      s = '0;
      if (c == 0) begin
        s.m0_start = 1'b1;
        s.m0_addr  = 27'h300;
      end
      if (c == 22) begin
        s.bus_done = 1'b1;
        s.bus_q    = 32'h0BADF00D;
      end
      applyStimulus(s);
      @(negedge clk);
      checkOutput($sformatf("tmo m0_done c%0d", c), m0_done, (c == 19));
      checkOutput($sformatf("tmo timeout_err c%0d", c), timeout_err, (c >= 19));
      if (c >= 19) checkOutput($sformatf("tmo m0_q c%0d", c), m0_q, 32'hFFFFFFFF);
    end
  endtask
`endif

  // Randomized traffic against a timestamp-based model. The model tracks
  // which requests are waiting and who owns the bus. A grant is decided on
  // any cycle the bus is free and something is waiting, and it becomes
  // visible as bus_start one cycle later. The owner's done follows the
  // MemoryUnit's done by one cycle.
  task automatic run_random(input int n_cycles);
    stim_t             s;
    bit                pend[2], was_pend[2];
    logic [ADDR_W-1:0] r_addr[2];
    logic [DATA_W-1:0] r_data[2];
    logic              r_we[2];
    logic              e_done[2];
    logic [DATA_W-1:0] e_q[2];
    logic              e_start = 1'b0;
    logic [ADDR_W-1:0] e_addr = '0;
    logic [DATA_W-1:0] e_data = '0;
    logic              e_we = 1'b0;
    int                last_g = 1, owner = -1, issue_c = 0, mem_due = -1, g;
    for (int m = 0; m < 2; m++) begin
      pend[m] = 1'b0;
      r_addr[m] = '0;
      r_data[m] = '0;
      r_we[m] = 1'b0;
      e_done[m] = 1'b0;
      e_q[m] = '0;
    end
    do_reset();
    for (int c = 0; c < n_cycles; c++) begin
      s = '0;
      if ($urandom_range(0, 3) == 0) begin
        s.m0_start = 1'b1;
        s.m0_addr  = ADDR_W'($urandom);
        s.m0_data  = $urandom;
        s.m0_we    = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 3) == 0) begin
        s.m1_start = 1'b1;
        s.m1_addr  = ADDR_W'($urandom);
        s.m1_data  = $urandom;
        s.m1_we    = 1'($urandom_range(0, 1));
      end
      if (mem_due == c) begin
        s.bus_done = 1'b1;
        s.bus_q    = $urandom;
        mem_due    = -1;
      end else if (owner < 0 && $urandom_range(0, 7) == 0) begin
        s.bus_done = 1'b1;
        s.bus_q    = $urandom;
      end
      applyStimulus(s);
      @(negedge clk);
      checkOutput($sformatf("rnd bus_start c%0d", c), bus_start, e_start);
      checkOutput($sformatf("rnd bus_addr c%0d", c), bus_addr, e_addr);
      checkOutput($sformatf("rnd bus_data c%0d", c), bus_data, e_data);
      checkOutput($sformatf("rnd bus_we c%0d", c), bus_we, e_we);
      checkOutput($sformatf("rnd m0_done c%0d", c), m0_done, e_done[0]);
      checkOutput($sformatf("rnd m1_done c%0d", c), m1_done, e_done[1]);
      checkOutput($sformatf("rnd m0_q c%0d", c), m0_q, e_q[0]);
      checkOutput($sformatf("rnd m1_q c%0d", c), m1_q, e_q[1]);
      checkOutput($sformatf("rnd timeout_err c%0d", c), timeout_err, 0);
      if (e_start) mem_due = c + $urandom_range(1, 6);

      was_pend  = pend;
      e_start   = 1'b0;
      e_done[0] = 1'b0;
      e_done[1] = 1'b0;
      if (owner < 0) begin
        if (pend[0] || pend[1]) begin
          g       = (pend[0] && pend[1]) ? 1 - last_g : (pend[0] ? 0 : 1);
          owner   = g;
          issue_c = c + 1;
          e_start = 1'b1;
          e_addr  = r_addr[g];
          e_data  = r_data[g];
          e_we    = r_we[g];
        end
      end else if (c > issue_c && s.bus_done) begin
        e_done[owner] = 1'b1;
        e_q[owner]    = s.bus_q;
        pend[owner]   = 1'b0;
        last_g        = owner;
        owner         = -1;
      end
      if (s.m0_start && !was_pend[0]) begin
        pend[0]   = 1'b1;
        r_addr[0] = s.m0_addr;
        r_data[0] = s.m0_data;
        r_we[0]   = s.m0_we;
      end
      if (s.m1_start && !was_pend[1]) begin
        pend[1]   = 1'b1;
        r_addr[1] = s.m1_addr;
        r_data[1] = s.m1_data;
        r_we[1]   = s.m1_we;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] bus_arbiter2 test starting");
    run_table();
    run_single_read();
    run_fairness();
    run_duplicate();
    run_reset_midwait();
`ifdef BUS_ARB_TIMEOUT_EN
    run_timeout();
`endif
    run_random(2000);
    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
